ram_pipelined: RTL and testbench
================================

// Module: ram_pipelined
// PURPOSE
//  Single-clock, one-read/one-write scratchpad RAM that supersedes the basic ram block used for systolic-array
//  operand and result buffers. Adds per-byte write enables, a selectable 0/1/2-cycle read latency with a
//  read_valid strobe, and a defined read/write collision policy. A clear engine zero-fills the whole array
//  after reset or on request, so feeders and drainers never read stale tiles.
// PARAMETERS
//  DATA_WIDTH     32  word width in bits; must be a multiple of BYTE_WIDTH
//  BYTE_WIDTH      8  write-enable granularity in bits
//  ADDR_WIDTH     12  depth is exactly 2**ADDR_WIDTH words (addresses 0..2**ADDR_WIDTH-1)
//  READ_LATENCY    1  0 = combinational read, 1 = one output register, 2 = two output registers
//  WRITE_FIRST     0  same-address read+write collision: 1 = read returns the new data, 0 = returns the old data
//  INIT_ON_RESET   1  1 = start a clear sweep automatically when reset is released
// PORTS
//  clk         in   1                      clock; all state changes on the rising edge
//  reset_n     in   1                      asynchronous, active-low reset
//  clear_req   in   1                      pulse: start a zero-fill sweep (accepted only while busy=0)
//  busy        out  1                      clear sweep in progress; read/write requests are ignored
//  read_req    in   1                      read request; accepted when busy=0
//  read_addr   in   ADDR_WIDTH             read word address
//  read_data   out  DATA_WIDTH             read word; valid when read_valid=1
//  read_valid  out  1                      one-cycle strobe, READ_LATENCY cycles after an accepted read_req
//  write_req   in   1                      write request; accepted when busy=0
//  write_addr  in   ADDR_WIDTH             write word address
//  write_data  in   DATA_WIDTH             write word
//  write_be    in   DATA_WIDTH/BYTE_WIDTH  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): read_data=0, read_valid=0, pipeline valids=0, clr_addr=0.
//    busy=INIT_ON_RESET, with state=CLEAR if INIT_ON_RESET=1, otherwise IDLE. Array contents are not reset.
//  - Clear FSM states: IDLE and CLEAR.
//    IDLE: clear_req=1 moves the FSM to CLEAR on the next edge, with clr_addr=0.
//    CLEAR: each cycle, write 0 to all lanes of mem[clr_addr] and increment clr_addr. After the edge that
//    writes address 2**ADDR_WIDTH-1, go to IDLE. A full sweep takes 2**ADDR_WIDTH cycles of busy=1.
//    clear_req while in CLEAR is ignored; the sweep does not restart.
//  - busy is registered and equals (state==CLEAR).
//  - Accepted write = write_req & ~busy. On the edge, only lanes whose write_be bit is set are updated.
//    write_be=0 is a legal no-op.
//  - Accepted read = read_req & ~busy. While busy=1, requests are dropped: no write happens and no read_valid.
//  - READ_LATENCY=0: read_data = mem[read_addr] combinationally and read_valid = read_req & ~busy
//    combinationally. Collision always returns the old data; WRITE_FIRST has no effect.
//  - READ_LATENCY=1: data is captured at the accept edge; read_valid=1 for exactly the following cycle.
//  - READ_LATENCY=2: there is one extra register stage; read_valid is asserted 2 cycles after the accept.
//    A new read may be accepted every cycle (fully pipelined).
//  - Registered modes: read_data holds its last value when no read completes; it is not zeroed.
//  - Collision (READ_LATENCY>=1, same address, both accepted on the same edge):
//    WRITE_FIRST=1 returns the old word with the enabled lanes replaced by write_data.
//    WRITE_FIRST=0 returns the old word.
//  - Reads already in flight when a clear begins still complete, with the data captured at their accept.
//  - Addresses wrap naturally: there is no out-of-range address, because depth is exactly 2**ADDR_WIDTH.
//  - reset_n asserted mid-sweep or mid-read: in-flight reads are lost (read_valid=0), and the FSM returns
//    to its reset state.
// STRUCTURE
//  - Shared package ram_pkg holds:
//    * latency constants RD_LAT_COMB=0, RD_LAT_REG=1, RD_LAT_REG2=2;
//    * collision constants READ_FIRST=0 and WRITE_FIRST=1;
//    * function num_lanes(DATA_WIDTH, BYTE_WIDTH).
//  - Sub-module ram_clear_fsm holds the state, clr_addr and busy, and drives the internal clear-write port.
//  - The top level contains the array, the write mux (clear vs. user), the collision bypass and the read
//    pipeline. Parameter legality (READ_LATENCY in 0..2, DATA_WIDTH % BYTE_WIDTH == 0) is checked at
//    elaboration.
// TESTING (DATA_WIDTH=32, BYTE_WIDTH=8, ADDR_WIDTH=4)
//  1. Reset release with INIT_ON_RESET=1 -> busy=1 for exactly 16 cycles. Then, with READ_LATENCY=1, reading
//     each address 0..15 gives read_data=0 and read_valid one cycle later.
//  2. Write addr 3 = 0xDEADBEEF (be=4'hF), then write addr 3 = 0x11223344 with be=4'b0101
//     -> reading addr 3 returns 0xDE22BE44.
//  3. Collision at addr 5 (old 0xAAAAAAAA, new 0x55555555, be=4'hF), READ_LATENCY=1
//     -> WRITE_FIRST=1 returns 0x55555555; WRITE_FIRST=0 returns 0xAAAAAAAA.
//  4. READ_LATENCY=2, back-to-back reads of addrs 1,2,3 on cycles t..t+2
//     -> read_valid high on t+2..t+4 with data in order; READ_LATENCY=0 returns the data in the same cycle.
//  5. clear_req with a write_req to addr 7 in the same cycle -> the write lands. Writes and reads issued
//     during busy are dropped with read_valid=0. A second clear_req mid-sweep does not extend busy past
//     16 cycles.
//  6. reset_n pulsed low for 1 cycle while a READ_LATENCY=2 read is in flight
//     -> read_valid stays 0, read_data=0, and the clear sweep restarts from address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the pipelined scratchpad RAM:
//   - read-latency selectors (RD_LAT_*)
//   - collision policy selectors (READ_FIRST / WRITE_FIRST)
//   - clear-engine state encoding
//   - num_lanes(): number of byte-enable lanes in a word
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int RD_LAT_COMB = 0;
    localparam int RD_LAT_REG  = 1;
    localparam int RD_LAT_REG2 = 2;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int num_lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// ----------------------------------------------------------------------------
// ram_clear_fsm
// Zero-fill engine. Sweeps every word address once, one word per cycle, and
// reports busy while the sweep is running.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   clear_req      start a sweep (only honoured while idle)
//   busy           registered, high for the whole sweep
//   clr_we         write strobe for the internal clear port
//   clr_addr       word address being zeroed this cycle
// ----------------------------------------------------------------------------
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam clr_state_t            RESET_STATE = (INIT_ON_RESET != 0) ? CLEAR : IDLE;

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            busy_q     <= (INIT_ON_RESET != 0);
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                // Address wraps back to 0 naturally after the last word.
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // busy is registered from the next state so it lines up with state_q.
        busy_d = (state_d == CLEAR);
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/ram_pipelined.sv
// ----------------------------------------------------------------------------
// ram_pipelined
// Single-clock 1R/1W scratchpad RAM with byte-lane write enables, a 0/1/2
// cycle read pipeline with read_valid strobe, a selectable same-address
// collision policy and a zero-fill clear engine.
// Ports:
//   clk, reset_n                  clock / asynchronous active-low reset
//   clear_req, busy               start zero-fill / sweep in progress
//   read_req, read_addr           read request (accepted when busy=0)
//   read_data, read_valid         read result and its one-cycle strobe
//   write_req, write_addr,
//   write_data, write_be          write request with per-byte enables
// ----------------------------------------------------------------------------
module ram_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_FIRST   = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                clear_req,
    output logic                                                busy,
    input  logic                                                read_req,
    input  logic [ADDR_WIDTH-1:0]                               read_addr,
    output logic [DATA_WIDTH-1:0]                               read_data,
    output logic                                                read_valid,
    input  logic                                                write_req,
    input  logic [ADDR_WIDTH-1:0]                               write_addr,
    input  logic [DATA_WIDTH-1:0]                               write_data,
    input  logic [ram_pkg::num_lanes(DATA_WIDTH,BYTE_WIDTH)-1:0] write_be
);

    localparam int LANES = ram_pkg::num_lanes(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY < ram_pkg::RD_LAT_COMB || READ_LATENCY > ram_pkg::RD_LAT_REG2) begin : g_bad_latency
        $error("ram_pipelined: READ_LATENCY must be 0, 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // Old word with the enabled lanes replaced by the new data.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) w[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return w;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    ram_clear_fsm #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_req(clear_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_acc = write_req & ~busy;
    assign rd_acc = read_req  & ~busy;

    // User writes are gated by busy, so the clear port and user port never
    // compete; the clear port still takes priority structurally.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_be[i]) begin
                    mem_q[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Word captured by a registered read; bypass merges a same-edge write.
    always_comb begin
        rd_word = mem_q[read_addr];
        if (WRITE_FIRST == ram_pkg::WRITE_FIRST && wr_acc && (write_addr == read_addr)) begin
            rd_word = merge_lanes(rd_word, write_data, write_be);
        end
    end

    if (READ_LATENCY == ram_pkg::RD_LAT_COMB) begin : g_lat0
        assign read_data  = mem_q[read_addr];
        assign read_valid = rd_acc;
    end else if (READ_LATENCY == ram_pkg::RD_LAT_REG) begin : g_lat1
        logic [DATA_WIDTH-1:0] data_p1_q;
        logic                  vld_p1_q;

        // Stage 1: capture at the accept edge; data holds when idle.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_p1_q <= '0;
                vld_p1_q  <= 1'b0;
            end else begin
                vld_p1_q <= rd_acc;
                if (rd_acc) data_p1_q <= rd_word;
            end
        end

        assign read_data  = data_p1_q;
        assign read_valid = vld_p1_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] data_p1_q, data_p2_q;
        logic                  vld_p1_q,  vld_p2_q;

        // Stage 1: capture at the accept edge.
        // Stage 2: output register, advanced only when stage 1 holds a read.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_p1_q <= '0;
                vld_p1_q  <= 1'b0;
                data_p2_q <= '0;
                vld_p2_q  <= 1'b0;
            end else begin
                vld_p1_q <= rd_acc;
                if (rd_acc) data_p1_q <= rd_word;
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) data_p2_q <= data_p1_q;
            end
        end

        assign read_data  = data_p2_q;
        assign read_valid = vld_p2_q;
    end

endmodule

// File: tb/tb_ram_pipelined.sv
// ----------------------------------------------------------------------------
// tb_ram_pipelined
// Four RAM instances (different latency / collision policy) share one
// stimulus stream. A word-array reference model predicts each read; expected
// results are queued per instance and popped by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_ram_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NL    = 4;
    localparam int DEPTH = 16;
    localparam int NDUT  = 4;
    localparam int LAT [NDUT] = '{1, 2, 0, 1};
    localparam int WF  [NDUT] = '{1, 1, 0, 0};

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic          clear_req  = 1'b0;
    logic          read_req   = 1'b0;
    logic          write_req  = 1'b0;
    logic [AW-1:0] read_addr  = '0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [NL-1:0] write_be   = '0;

    logic          busyv  [NDUT];
    logic          rvalid [NDUT];
    logic [DW-1:0] rdata  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_pipelined #(
            .DATA_WIDTH   (DW),
            .BYTE_WIDTH   (8),
            .ADDR_WIDTH   (AW),
            .READ_LATENCY (LAT[g]),
            .WRITE_FIRST  (WF[g]),
            .INIT_ON_RESET(1)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear_req (clear_req),
            .busy      (busyv[g]),
            .read_req  (read_req),
            .read_addr (read_addr),
            .read_data (rdata[g]),
            .read_valid(rvalid[g]),
            .write_req (write_req),
            .write_addr(write_addr),
            .write_data(write_data),
            .write_be  (write_be)
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q [NDUT][$];
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_left = 0;
    int            clr_ptr  = 0;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Byte-enable expanded into a bit mask, then blended.
    function automatic logic [DW-1:0] blend(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NL-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < NL; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic mon(input int k);
        exp_t e;
        while (q[k].size() != 0 && q[k][0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL dut%0d read_valid missing actual=0 required=1 (due %0d, now %0d)", k, q[k][0].due, cyc);
            void'(q[k].pop_front());
        end
        if (rvalid[k] === 1'b1) begin
            if (q[k].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut%0d read_valid unexpected actual=1 required=0 (cycle %0d)", k, cyc);
            end else begin
                e = q[k].pop_front();
                check($sformatf("dut%0d read_data", k), rdata[k], e.data);
                check($sformatf("dut%0d valid_cycle", k), 32'(cyc), 32'(e.due));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) mon(k);
    end

    // Apply one cycle of stimulus, advance the model, and wait for the edge.
    task automatic step(input bit rd, input int ra, input bit wr, input int wa,
                        input logic [DW-1:0] wd, input logic [NL-1:0] be, input bit clr);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        bit            busy_m;
        read_req   = rd;
        read_addr  = AW'(ra);
        write_req  = wr;
        write_addr = AW'(wa);
        write_data = wd;
        write_be   = be;
        clear_req  = clr;
        busy_m     = (clr_left > 0);
        for (int k = 0; k < NDUT; k++) check($sformatf("dut%0d busy", k), 32'(busyv[k]), 32'(busy_m));
        if (busy_m) begin
            mem_m[clr_ptr] = '0;
            clr_ptr++;
            clr_left--;
        end else begin
            old_w = mem_m[ra];
            new_w = blend(mem_m[wa], wd, be);
            if (rd) begin
                for (int k = 0; k < NDUT; k++) begin
                    exp_t e;
                    e.data = (wr && wa == ra && LAT[k] > 0 && WF[k] == 1) ? new_w : old_w;
                    e.due  = cyc + LAT[k];
                    q[k].push_back(e);
                end
            end
            if (wr) mem_m[wa] = new_w;
            if (clr) begin
                clr_left = DEPTH;
                clr_ptr  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset(input int hold);
        read_req  = 0;
        write_req = 0;
        clear_req = 0;
        reset_n   = 0;
        for (int k = 0; k < NDUT; k++) q[k].delete();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d reset read_valid", k), 32'(rvalid[k]), 32'd0);
            check($sformatf("dut%0d reset busy", k), 32'(busyv[k]), 32'd1);
            if (LAT[k] > 0) check($sformatf("dut%0d reset read_data", k), rdata[k], 32'd0);
        end
        repeat (hold) @(posedge clk);
        #1;
        reset_n  = 1;
        clr_left = DEPTH;
        clr_ptr  = 0;
    endtask

    initial begin
        #2;
        do_reset(3);

        // Initial sweep: requests during busy are dropped.
        for (int i = 0; i < DEPTH; i++) step(1, i, 1, (i + 15) % DEPTH, 32'hFFFF_FFFF, 4'hF, 0);
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, '0, '0, 0);

        // Partial byte-lane write.
        step(0, 0, 1, 3, 32'hDEAD_BEEF, 4'hF, 0);
        step(0, 0, 1, 3, 32'h1122_3344, 4'b0101, 0);
        step(1, 3, 0, 0, '0, '0, 0);
        step(0, 0, 1, 3, 32'h0BAD_F00D, 4'b0000, 0);
        step(1, 3, 0, 0, '0, '0, 0);

        // Same-address collision.
        step(0, 0, 1, 5, 32'hAAAA_AAAA, 4'hF, 0);
        step(1, 5, 1, 5, 32'h5555_5555, 4'hF, 0);
        step(1, 5, 1, 5, 32'h0000_0000, 4'b1001, 0);
        step(1, 5, 0, 0, '0, '0, 0);

        // Back-to-back reads.
        step(0, 0, 1, 1, 32'h0101_0101, 4'hF, 0);
        step(0, 0, 1, 2, 32'h0202_0202, 4'hF, 0);
        step(0, 0, 1, 15, 32'hF0F0_F0F0, 4'hF, 0);
        step(1, 1, 0, 0, '0, '0, 0);
        step(1, 2, 0, 0, '0, '0, 0);
        step(1, 3, 0, 0, '0, '0, 0);
        step(1, 15, 0, 0, '0, '0, 0);
        step(1, 0, 0, 0, '0, '0, 0);
        idle(3);

        // Clear together with a write (and colliding read), then a repeated
        // clear_req and dropped traffic mid-sweep.
        step(1, 7, 1, 7, 32'hCAFE_F00D, 4'hF, 1);
        for (int i = 0; i < DEPTH; i++)
            step(1, int'($urandom_range(0, DEPTH-1)), 1, int'($urandom_range(0, DEPTH-1)),
                 $urandom, 4'hF, i == 5);
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, '0, '0, 0);

        // Randomised traffic with frequent collisions and occasional clears.
        for (int i = 0; i < 400; i++) begin
            int ra;
            int wa;
            ra = int'($urandom_range(0, DEPTH-1));
            wa = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, DEPTH-1));
            step(bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)), wa,
                 $urandom, NL'($urandom), $urandom_range(0, 59) == 0);
        end

        // Reset pulse with a read in flight.
        while (clr_left > 0) idle(1);
        step(0, 0, 1, 9, 32'h1357_9BDF, 4'hF, 0);
        step(1, 9, 0, 0, '0, '0, 0);
        do_reset(1);
        idle(DEPTH);
        for (int i = 8; i < 12; i++) step(1, i, 0, 0, '0, '0, 0);
        idle(4);

        for (int k = 0; k < NDUT; k++) check($sformatf("dut%0d pending_reads", k), 32'(q[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
